// File: rtl/tmboc_corr_dump_if.sv
// Sample/replica inputs and dump outputs of the TMBOC integrate-and-dump correlator.
// Handshake: a dump is offered while tx_corr_valid is high and is consumed on the first
// clock edge that samples rx_corr_ack high; ack is ignored while valid is low.
interface tmboc_corr_dump_if #(
  parameter int SRC_WIDTH  = 16,
  parameter int CORR_WIDTH = 32
);
  logic                         rx_trk_rst;
  logic signed [SRC_WIDTH-1:0]  rx_src_real;
  logic signed [SRC_WIDTH-1:0]  rx_src_imag;
  logic                         rx_loc_tmbocE;
  logic                         rx_loc_tmbocP;
  logic                         rx_loc_tmbocL;
  logic                         rx_prn_sop;
  logic                         rx_corr_ack;
  logic signed [CORR_WIDTH-1:0] tx_corr_ie;
  logic signed [CORR_WIDTH-1:0] tx_corr_qe;
  logic signed [CORR_WIDTH-1:0] tx_corr_ip;
  logic signed [CORR_WIDTH-1:0] tx_corr_qp;
  logic signed [CORR_WIDTH-1:0] tx_corr_il;
  logic signed [CORR_WIDTH-1:0] tx_corr_ql;
  logic                         tx_corr_valid;
  logic                         tx_corr_overrun;
  logic                         tx_corr_sat;
  logic [7:0]                   tx_dump_cnt;

  modport master (
    output rx_trk_rst, rx_src_real, rx_src_imag, rx_loc_tmbocE, rx_loc_tmbocP,
           rx_loc_tmbocL, rx_prn_sop, rx_corr_ack,
    input  tx_corr_ie, tx_corr_qe, tx_corr_ip, tx_corr_qp, tx_corr_il, tx_corr_ql,
           tx_corr_valid, tx_corr_overrun, tx_corr_sat, tx_dump_cnt
  );

  modport slave (
    input  rx_trk_rst, rx_src_real, rx_src_imag, rx_loc_tmbocE, rx_loc_tmbocP,
           rx_loc_tmbocL, rx_prn_sop, rx_corr_ack,
    output tx_corr_ie, tx_corr_qe, tx_corr_ip, tx_corr_qp, tx_corr_il, tx_corr_ql,
           tx_corr_valid, tx_corr_overrun, tx_corr_sat, tx_dump_cnt
  );
endinterface

// File: rtl/tmboc_corr_dump.sv
// Integrate-and-dump correlator: six saturating E/P/L x I/Q accumulators dumped every
// DUMP_PERIODS PRN periods; the sop sample always opens the new integration.
module tmboc_corr_dump #(
  parameter int SRC_WIDTH    = 16,
  parameter int CORR_WIDTH   = 32,
  parameter int DUMP_PERIODS = 1
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  tmboc_corr_dump_if.slave      corr_if,
  output logic                  dbg_state_o
);
  typedef enum logic {S_WAIT_SOP = 1'b0, S_ACCUM = 1'b1} state_t;
  typedef logic signed [CORR_WIDTH-1:0] acc_t;
  localparam int         NACC = 6;
  localparam logic [7:0] DP_L = 8'(DUMP_PERIODS);

  state_t     state_q, state_d;
  logic [7:0] per_q, per_d;
  logic       sat_q, sat_d;
  acc_t       acc_q [NACC];
  acc_t       acc_d [NACC];
  acc_t       out_q [NACC];
  acc_t       out_d [NACC];
  acc_t       load_w [NACC];
  acc_t       sum_w [NACC];
  logic [NACC-1:0] ovf_w;
  logic       valid_q, valid_d, ovr_q, ovr_d, osat_q, osat_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dump_w;
  logic [2:0] rep_w;

  assign rep_w = {corr_if.rx_loc_tmbocL, corr_if.rx_loc_tmbocP, corr_if.rx_loc_tmbocE};

  // Lane order: IE, QE, IP, QP, IL, QL. Negation is one bit wider so -(min) is exact.
  for (genvar g = 0; g < NACC; g++) begin : g_lane
    logic signed [SRC_WIDTH:0]  src_ext;
    logic signed [SRC_WIDTH:0]  prod;
    logic signed [CORR_WIDTH:0] wide;
    assign src_ext = (g % 2 == 0) ? {corr_if.rx_src_real[SRC_WIDTH-1], corr_if.rx_src_real}
                                  : {corr_if.rx_src_imag[SRC_WIDTH-1], corr_if.rx_src_imag};
    assign prod      = rep_w[g/2] ? src_ext : -src_ext;
    assign load_w[g] = {{(CORR_WIDTH-SRC_WIDTH-1){prod[SRC_WIDTH]}}, prod};
    assign wide      = {acc_q[g][CORR_WIDTH-1], acc_q[g]} + {load_w[g][CORR_WIDTH-1], load_w[g]};
    assign ovf_w[g]  = wide[CORR_WIDTH] != wide[CORR_WIDTH-1];
    assign sum_w[g]  = !ovf_w[g] ? wide[CORR_WIDTH-1:0]
                     : wide[CORR_WIDTH] ? {1'b1, {(CORR_WIDTH-1){1'b0}}}
                                        : {1'b0, {(CORR_WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    sat_d   = sat_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    osat_d  = osat_q;
    cnt_d   = cnt_q;
    dump_w  = 1'b0;
    if (corr_if.rx_trk_rst) begin
      state_d = S_WAIT_SOP;
      per_d   = '0;
      sat_d   = 1'b0;
      for (int k = 0; k < NACC; k++) acc_d[k] = '0;
    end else begin
      case (state_q)
        S_WAIT_SOP: begin
          if (corr_if.rx_prn_sop) begin
            state_d = S_ACCUM;
            per_d   = 8'd1;
            sat_d   = 1'b0;
            acc_d   = load_w;
          end
        end
        default: begin
          if (corr_if.rx_prn_sop && per_q == DP_L) begin
            dump_w = 1'b1;
            out_d  = acc_q;
            osat_d = sat_q;
            cnt_d  = cnt_q + 8'd1;
            acc_d  = load_w;
            per_d  = 8'd1;
            sat_d  = 1'b0;
          end else begin
            acc_d = sum_w;
            sat_d = sat_q | (|ovf_w);
            if (corr_if.rx_prn_sop) per_d = per_q + 8'd1;
          end
        end
      endcase
    end
    // Overrun is raised only by a dump that lands on an unacked one; a plain ack clears it.
    if (dump_w) begin
      valid_d = 1'b1;
      if (valid_q && !corr_if.rx_corr_ack) ovr_d = 1'b1;
      else if (valid_q)                    ovr_d = 1'b0;
    end else if (valid_q && corr_if.rx_corr_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q <= S_WAIT_SOP;
      per_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      osat_q  <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < NACC; k++) begin
        acc_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      osat_q  <= osat_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < NACC; k++) begin
        acc_q[k] <= acc_d[k];
        out_q[k] <= out_d[k];
      end
    end
  end

  assign corr_if.tx_corr_ie      = out_q[0];
  assign corr_if.tx_corr_qe      = out_q[1];
  assign corr_if.tx_corr_ip      = out_q[2];
  assign corr_if.tx_corr_qp      = out_q[3];
  assign corr_if.tx_corr_il      = out_q[4];
  assign corr_if.tx_corr_ql      = out_q[5];
  assign corr_if.tx_corr_valid   = valid_q;
  assign corr_if.tx_corr_overrun = ovr_q;
  assign corr_if.tx_corr_sat     = osat_q;
  assign corr_if.tx_dump_cnt     = cnt_q;
  assign dbg_state_o             = state_q;
endmodule

// File: tb/tb_tmboc_corr_dump.sv
// Bench for tmboc_corr_dump: two instances (20-bit sums/1 period, 32-bit sums/3 periods)
// share one stimulus stream and are checked against an arithmetic model every cycle.
module tb_tmboc_corr_dump;
  logic rx_clk = 1'b0;
  logic rx_rst;
  logic trk, sop, ack, e_b, p_b, l_b;
  logic signed [15:0] sr, si;
  logic dbg1, dbg3;
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 rx_clk = ~rx_clk;

  tmboc_corr_dump_if #(.SRC_WIDTH(16), .CORR_WIDTH(20)) if1 ();
  tmboc_corr_dump_if #(.SRC_WIDTH(16), .CORR_WIDTH(32)) if3 ();

  assign if1.rx_trk_rst = trk;     assign if3.rx_trk_rst = trk;
  assign if1.rx_src_real = sr;     assign if3.rx_src_real = sr;
  assign if1.rx_src_imag = si;     assign if3.rx_src_imag = si;
  assign if1.rx_loc_tmbocE = e_b;  assign if3.rx_loc_tmbocE = e_b;
  assign if1.rx_loc_tmbocP = p_b;  assign if3.rx_loc_tmbocP = p_b;
  assign if1.rx_loc_tmbocL = l_b;  assign if3.rx_loc_tmbocL = l_b;
  assign if1.rx_prn_sop = sop;     assign if3.rx_prn_sop = sop;
  assign if1.rx_corr_ack = ack;    assign if3.rx_corr_ack = ack;

  tmboc_corr_dump #(.SRC_WIDTH(16), .CORR_WIDTH(20), .DUMP_PERIODS(1)) u_dut1 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .corr_if(if1), .dbg_state_o(dbg1));
  tmboc_corr_dump #(.SRC_WIDTH(16), .CORR_WIDTH(32), .DUMP_PERIODS(3)) u_dut3 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .corr_if(if3), .dbg_state_o(dbg3));

  // ---------------- model ----------------
  int     dp [2] = '{1, 3};
  longint vmax [2] = '{(longint'(1) << 19) - 1, (longint'(1) << 31) - 1};
  bit     m_active [2], m_isat [2], m_valid [2], m_ovr [2], m_osat [2];
  int     m_per [2], m_cnt [2];
  longint m_acc [2][6];
  longint m_out [2][6];
  bit     md;
  longint mv;
  string  lane_name [6] = '{"ie", "qe", "ip", "qp", "il", "ql"};

  function automatic longint prod(int k);
    longint s;
    logic   b;
    s = (k % 2 == 0) ? longint'(sr) : longint'(si);
    b = (k / 2 == 0) ? e_b : (k / 2 == 1) ? p_b : l_b;
    return b ? s : -s;
  endfunction

  always @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 0; m_isat[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_osat[i] = 0;
        m_per[i] = 0; m_cnt[i] = 0;
        for (int k = 0; k < 6; k++) begin m_acc[i][k] = 0; m_out[i][k] = 0; end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        md = !trk && m_active[i] && sop && (m_per[i] == dp[i]);
        if (md) begin
          if (m_valid[i] && !ack) m_ovr[i] = 1;
          else if (m_valid[i])    m_ovr[i] = 0;
          m_valid[i] = 1;
          m_out[i] = m_acc[i];
          m_osat[i] = m_isat[i];
          m_cnt[i] = (m_cnt[i] + 1) % 256;
        end else if (m_valid[i] && ack) begin
          m_valid[i] = 0;
          m_ovr[i] = 0;
        end
        if (trk) begin
          m_active[i] = 0; m_per[i] = 0; m_isat[i] = 0;
          for (int k = 0; k < 6; k++) m_acc[i][k] = 0;
        end else if (sop && (!m_active[i] || md)) begin
          m_active[i] = 1; m_per[i] = 1; m_isat[i] = 0;
          for (int k = 0; k < 6; k++) m_acc[i][k] = prod(k);
        end else if (m_active[i]) begin
          if (sop) m_per[i]++;
          for (int k = 0; k < 6; k++) begin
            mv = m_acc[i][k] + prod(k);
            if (mv > vmax[i])        begin mv = vmax[i];      m_isat[i] = 1; end
            else if (mv < -vmax[i] - 1) begin mv = -vmax[i] - 1; m_isat[i] = 1; end
            m_acc[i][k] = mv;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint dut_out(int i, int k);
    if (i == 0) begin
      case (k)
        0: return longint'(if1.tx_corr_ie);
        1: return longint'(if1.tx_corr_qe);
        2: return longint'(if1.tx_corr_ip);
        3: return longint'(if1.tx_corr_qp);
        4: return longint'(if1.tx_corr_il);
        default: return longint'(if1.tx_corr_ql);
      endcase
    end
    case (k)
      0: return longint'(if3.tx_corr_ie);
      1: return longint'(if3.tx_corr_qe);
      2: return longint'(if3.tx_corr_ip);
      3: return longint'(if3.tx_corr_qp);
      4: return longint'(if3.tx_corr_il);
      default: return longint'(if3.tx_corr_ql);
    endcase
  endfunction

  function automatic logic [10:0] dut_flags(int i);
    if (i == 0) return {if1.tx_corr_valid, if1.tx_corr_overrun, if1.tx_corr_sat, if1.tx_dump_cnt};
    return {if3.tx_corr_valid, if3.tx_corr_overrun, if3.tx_corr_sat, if3.tx_dump_cnt};
  endfunction

  always @(negedge rx_clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 6; k++)
          chk($sformatf("u%0d_%s", i, lane_name[k]), dut_out(i, k), m_out[i][k]);
        chk($sformatf("u%0d_valid", i),   longint'(dut_flags(i)[10]), longint'(m_valid[i]));
        chk($sformatf("u%0d_overrun", i), longint'(dut_flags(i)[9]),  longint'(m_ovr[i]));
        chk($sformatf("u%0d_sat", i),     longint'(dut_flags(i)[8]),  longint'(m_osat[i]));
        chk($sformatf("u%0d_cnt", i),     longint'(dut_flags(i)[7:0]), longint'(m_cnt[i]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int r, input int q, input logic e, input logic p, input logic l,
                      input logic s, input logic a, input logic t);
    sr = 16'(r); si = 16'(q); e_b = e; p_b = p; l_b = l; sop = s; ack = a; trk = t;
    @(posedge rx_clk);
    #1;
  endtask

  initial begin
    rx_rst = 1'b1;
    step(0, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0, 0);
    rx_rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", longint'(if1.tx_corr_valid), 0);
    chk("rst_cnt", longint'(if1.tx_dump_cnt), 0);
    chk("rst_ip", longint'(if1.tx_corr_ip), 0);

    // Constant 100/-50, all replicas +1, ten samples.
    step(100, -50, 1, 1, 1, 1, 0, 0);
    for (int j = 1; j < 10; j++) step(100, -50, 1, 1, 1, 0, 0, 0);
    // This sop sample opens the second integration: P=-1, E alternating from +1.
    step(100, -50, 1, 0, 1, 1, 0, 0);
    chk("t1_ip", longint'(if1.tx_corr_ip), 1000);
    chk("t1_qp", longint'(if1.tx_corr_qp), -500);
    chk("t1_ie", longint'(if1.tx_corr_ie), 1000);
    chk("t1_ql", longint'(if1.tx_corr_ql), -500);
    chk("t1_valid", longint'(if1.tx_corr_valid), 1);
    chk("t1_cnt", longint'(if1.tx_dump_cnt), 1);
    for (int j = 1; j < 10; j++) step(100, -50, (j % 2 == 0), 0, 1, 0, 0, 0);
    step(5, 2, 1, 1, 1, 1, 0, 0);
    chk("t2_ip", longint'(if1.tx_corr_ip), -1000);
    chk("t2_qp", longint'(if1.tx_corr_qp), 500);
    chk("t2_ie", longint'(if1.tx_corr_ie), 0);
    chk("t2_qe", longint'(if1.tx_corr_qe), 0);
    chk("t2_overrun", longint'(if1.tx_corr_overrun), 1);
    step(5, 2, 1, 1, 1, 0, 1, 0);
    chk("ack_valid", longint'(if1.tx_corr_valid), 0);
    chk("ack_overrun", longint'(if1.tx_corr_overrun), 0);

    // Ack arriving in the same cycle as the next dump.
    for (int j = 0; j < 2; j++) step(5, 2, 1, 1, 1, 0, 0, 0);
    step(5, 2, 1, 1, 1, 1, 0, 0);
    chk("t4_ip", longint'(if1.tx_corr_ip), 20);
    for (int j = 0; j < 2; j++) step(5, 2, 1, 1, 1, 0, 0, 0);
    step(5, 2, 1, 1, 1, 1, 1, 0);
    chk("coinc_ip", longint'(if1.tx_corr_ip), 15);
    chk("coinc_qp", longint'(if1.tx_corr_qp), 6);
    chk("coinc_valid", longint'(if1.tx_corr_valid), 1);
    chk("coinc_overrun", longint'(if1.tx_corr_overrun), 0);

    // Restart both, then three-period integration on the second instance.
    step(0, 0, 1, 1, 1, 0, 1, 1);
    step(0, 0, 1, 1, 1, 0, 1, 0);
    chk("u3_idle_valid", longint'(if3.tx_corr_valid), 0);
    for (int pd = 0; pd < 3; pd++) begin
      step(1, 1, 1, 1, 1, 1, 0, 0);
      chk($sformatf("u3_sop%0d_valid", pd + 1), longint'(if3.tx_corr_valid), 0);
      for (int j = 1; j < 8; j++) step(1, 1, 1, 1, 1, 0, 0, 0);
    end
    step(1, 1, 1, 1, 1, 1, 0, 0);
    chk("u3_sop4_valid", longint'(if3.tx_corr_valid), 1);
    chk("u3_sop4_ip", longint'(if3.tx_corr_ip), 24);

    // Saturation on the 20-bit instance, then a clean dump.
    step(1, 1, 1, 1, 1, 0, 1, 0);
    step(32767, 0, 1, 1, 1, 1, 0, 0);
    for (int j = 1; j < 70000; j++) step(32767, 0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    chk("sat_ip", longint'(if1.tx_corr_ip), 524287);
    chk("sat_flag", longint'(if1.tx_corr_sat), 1);
    for (int j = 1; j < 10; j++) step(1, 0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    chk("clean_ip", longint'(if1.tx_corr_ip), 10);
    chk("clean_sat", longint'(if1.tx_corr_sat), 0);
    chk("clean_cnt", longint'(if1.tx_dump_cnt), 10);

    // Tracking restart mid-integration with a dump still pending.
    for (int j = 0; j < 3; j++) step(2, 0, 1, 1, 1, 0, 0, 0);
    step(2, 0, 1, 1, 1, 0, 0, 1);
    chk("trk_valid", longint'(if1.tx_corr_valid), 1);
    step(3, 0, 1, 1, 1, 1, 0, 0);
    chk("trk_sop_cnt", longint'(if1.tx_dump_cnt), 10);
    chk("trk_sop_ip", longint'(if1.tx_corr_ip), 10);
    chk("trk_sop_valid", longint'(if1.tx_corr_valid), 1);
    for (int j = 0; j < 4; j++) step(3, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 1, 0, 0);
    chk("trk_next_ip", longint'(if1.tx_corr_ip), 15);
    chk("trk_next_cnt", longint'(if1.tx_dump_cnt), 11);
    step(0, 0, 1, 1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
